reload_sequencer: RTL and testbench

Upstream control stage for the self-reloading 4-bit counter. Queues up to DEPTH reload values from software or a host. Watches the counter's live count. When the count reaches a programmable terminal value, it drives a one-cycle load pulse with the next queued value, so the counter runs a scripted series of segments without host intervention per segment.

---
 rtl/reload_seq_pkg.sv | 19 +
 rtl/reload_fifo.sv | 65 ++++++
 rtl/reload_sequencer.sv | 97 +++++++++
 tb/tb_reload_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reload_seq_pkg.sv
// Shared definitions for the reload sequencer and its companion 4-bit counter:
// FSM encodings and default count/queue geometry.
package reload_seq_pkg;

   localparam int RS_WIDTH = 4;
   localparam int RS_DEPTH = 4;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ARMED    = 2'd1,
      S_COOLDOWN = 2'd2
   } rs_state_t;

   // Level counter must hold 0..depth inclusive.
   function automatic int lvl_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/reload_fifo.sv
// Small synchronous FIFO of reload values; the head entry is always presented
// so the sequencer can drive it onto the load-value bus without a read cycle.
module reload_fifo
   import reload_seq_pkg::*;
#(
   parameter int WIDTH = RS_WIDTH,
   parameter int DEPTH = RS_DEPTH,
   parameter int LVL_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [LVL_W-1:0] o_level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_level == LVL_W'(DEPTH));
   assign o_empty = (r_level == '0);
   assign o_level = r_level;
   assign o_head  = r_mem[r_rd_ptr];

   // Requests are qualified here so the level can never over- or under-flow.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/reload_sequencer.sv
// Feeds queued reload values to the counter: when the live count hits the
// terminal value, a one-cycle load strobe carries the next queued value.
module reload_sequencer
   import reload_seq_pkg::*;
#(
   parameter int WIDTH = RS_WIDTH,
   parameter int DEPTH = RS_DEPTH,
   parameter int LVL_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_valid_i,
   input  logic [WIDTH-1:0] push_data_i,
   output logic             push_ready_o,
   input  logic             enable_i,
   input  logic [WIDTH-1:0] term_val_i,
   input  logic [WIDTH-1:0] count_i,
   output logic             load_o,
   output logic [WIDTH-1:0] load_val_o,
   output logic             busy_o,
   output logic [LVL_W-1:0] fifo_level_o,
   output logic             underrun_o
);

   rs_state_t        r_state;
   rs_state_t        w_state_next;
   logic             r_underrun;
   logic [WIDTH-1:0] w_head;
   logic             w_full;
   logic             w_empty;
   logic             w_hit;
   logic             w_fire;

   reload_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (push_valid_i),
      .i_data  (push_data_i),
      .i_pop   (w_fire),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (fifo_level_o)
   );

   assign w_hit        = enable_i && (count_i == term_val_i);
   assign w_fire       = (r_state == S_ARMED) && w_hit;
   assign push_ready_o = !w_full;
   assign load_o       = w_fire;
   assign load_val_o   = (r_state == S_ARMED) ? w_head : '0;
   assign busy_o       = (r_state == S_ARMED) || (r_state == S_COOLDOWN);
   assign underrun_o   = r_underrun;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (enable_i && !w_empty) begin
               w_state_next = S_ARMED;
            end
         end
         S_ARMED: begin
            if (!enable_i) begin
               w_state_next = S_IDLE;
            end else if (w_fire) begin
               w_state_next = S_COOLDOWN;
            end
         end
         // One masked cycle so a reload equal to the terminal value cannot refire.
         S_COOLDOWN: begin
            if (enable_i && !w_empty) begin
               w_state_next = S_ARMED;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_underrun <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_hit && w_empty && (r_state != S_COOLDOWN)) begin
            r_underrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reload_sequencer.sv
// Directed bench for reload_sequencer: expected load values are queued when
// stimulus is issued and a negedge monitor matches them against load strobes.
module tb_reload_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       push_valid_i = 1'b0;
   logic [3:0] push_data_i = '0;
   logic       push_ready_o;
   logic       enable_i = 1'b0;
   logic [3:0] term_val_i = '0;
   logic [3:0] count_i;
   logic       load_o;
   logic [3:0] load_val_o;
   logic       busy_o;
   logic [2:0] fifo_level_o;
   logic       underrun_o;

   logic       cnt_run = 1'b0;
   logic [3:0] cnt_drv = '0;
   logic [3:0] cnt_model = '0;

   logic [3:0] sb_q [$];
   int         total = 0;
   int         bad = 0;
   int         loads_seen = 0;

   always #5 clk = ~clk;

   reload_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .push_valid_i (push_valid_i),
      .push_data_i  (push_data_i),
      .push_ready_o (push_ready_o),
      .enable_i     (enable_i),
      .term_val_i   (term_val_i),
      .count_i      (count_i),
      .load_o       (load_o),
      .load_val_o   (load_val_o),
      .busy_o       (busy_o),
      .fifo_level_o (fifo_level_o),
      .underrun_o   (underrun_o)
   );

   // Behavioural stand-in for the self-reloading counter.
   assign count_i = cnt_run ? cnt_model : cnt_drv;

   always @(posedge clk) begin
      if (!cnt_run)    cnt_model <= 4'd0;
      else if (load_o) cnt_model <= load_val_o;
      else             cnt_model <= cnt_model + 4'd1;
   end

   task automatic check(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every load strobe must match the oldest expected reload value.
   always @(negedge clk) begin
      if (!reset && load_o) begin
         loads_seen = loads_seen + 1;
         $display("load: val=%0d count=%0d term=%0d", load_val_o, count_i, term_val_i);
         if (sb_q.size() == 0) begin
            check("unexpected_load", 1, 0);
         end else begin
            check("load_val", int'(load_val_o), int'(sb_q.pop_front()));
         end
         check("load_at_term", int'(count_i), int'(term_val_i));
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      push_valid_i = 1'b0;
      enable_i = 1'b0;
      cnt_run = 1'b0;
      cnt_drv = 4'd0;
      #3;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_push(input logic [3:0] v);
      bit ok;
      ok = 1'b0;
      push_valid_i = 1'b1;
      push_data_i = v;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (push_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("push_timeout", 0, 1);
      @(posedge clk); #1;
      push_valid_i = 1'b0;
      $display("push: val=%0d accepted=%0d", v, ok);
   endtask

   task automatic wait_clean();
      @(negedge clk);
      check("sb_drained", sb_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int base;
      bit seen;

      // Reset state
      #12;
      check("rst_level", int'(fifo_level_o), 0);
      check("rst_busy", int'(busy_o), 0);
      check("rst_load", int'(load_o), 0);
      check("rst_load_val", int'(load_val_o), 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_push_ready", int'(push_ready_o), 1);
      check("rst_underrun", int'(underrun_o), 0);
      @(posedge clk); #1;

      // 1: asynchronous reset while armed with three entries
      do_push(4'd3); do_push(4'd4); do_push(4'd5);
      term_val_i = 4'd15;
      cnt_drv = 4'd0;
      enable_i = 1'b1;
      @(posedge clk); #1;
      check("t1_busy_armed", int'(busy_o), 1);
      check("t1_level3", int'(fifo_level_o), 3);
      #2;
      reset = 1'b1;
      #1;
      check("t1_level0", int'(fifo_level_o), 0);
      check("t1_busy0", int'(busy_o), 0);
      check("t1_load0", int'(load_o), 0);
      check("t1_load_val0", int'(load_val_o), 0);
      enable_i = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("t1_push_ready", int'(push_ready_o), 1);
      check("t1_underrun", int'(underrun_o), 0);
      @(posedge clk); #1;

      // 2: scripted segments 5, 9, 2 from a free-running counter, then underrun
      do_reset();
      do_push(4'd5); sb_q.push_back(4'd5);
      do_push(4'd9); sb_q.push_back(4'd9);
      do_push(4'd2); sb_q.push_back(4'd2);
      term_val_i = 4'd15;
      enable_i = 1'b1;
      cnt_run = 1'b1;
      base = loads_seen;
      seen = 1'b0;
      for (int n = 0; n < 120; n++) begin
         @(negedge clk);
         if (underrun_o) begin
            seen = 1'b1;
            break;
         end
      end
      check("t2_underrun_set", int'(seen), 1);
      check("t2_loads_before_underrun", loads_seen - base, 3);
      check("t2_count_wrapped", int'(count_i), 0);
      check("t2_level0", int'(fifo_level_o), 0);
      check("t2_idle", int'(busy_o), 0);
      enable_i = 1'b0;
      cnt_run = 1'b0;
      wait_clean();

      // 3: fifth push held off while full
      do_reset();
      do_push(4'd1); do_push(4'd2); do_push(4'd3); do_push(4'd4);
      push_valid_i = 1'b1;
      push_data_i = 4'd5;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check("t3_ready_full", int'(push_ready_o), 0);
         check("t3_level4", int'(fifo_level_o), 4);
      end
      @(posedge clk); #1;
      push_valid_i = 1'b0;
      wait_clean();

      // 4: reload equal to term; cooldown masks the immediate second hit
      do_reset();
      do_push(4'd7); sb_q.push_back(4'd7);
      do_push(4'd7); sb_q.push_back(4'd7);
      term_val_i = 4'd7;
      cnt_drv = 4'd7;
      enable_i = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_first_fire", int'(load_o), 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_cooldown_masked", int'(load_o), 0);
      check("t4_cooldown_busy", int'(busy_o), 1);
      check("t4_level1", int'(fifo_level_o), 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_second_fire", int'(load_o), 1);
      @(posedge clk); #1;
      enable_i = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_level0", int'(fifo_level_o), 0);
      check("t4_underrun", int'(underrun_o), 0);
      wait_clean();

      // 5: push on a fire edge, first when full (refused), then at level 3
      do_reset();
      do_push(4'd1); sb_q.push_back(4'd1);
      do_push(4'd2); sb_q.push_back(4'd2);
      do_push(4'd3); sb_q.push_back(4'd3);
      do_push(4'd4); sb_q.push_back(4'd4);
      term_val_i = 4'd9;
      cnt_drv = 4'd0;
      enable_i = 1'b1;
      @(posedge clk); #1;
      push_valid_i = 1'b1;
      push_data_i = 4'd6;
      cnt_drv = 4'd9;
      @(negedge clk);
      check("t5_ready_full_on_fire", int'(push_ready_o), 0);
      @(posedge clk); #1;
      push_valid_i = 1'b0;
      cnt_drv = 4'd0;
      @(negedge clk);
      check("t5_level3_after_refused", int'(fifo_level_o), 3);
      @(posedge clk); #1;
      push_valid_i = 1'b1;
      push_data_i = 4'd6;
      sb_q.push_back(4'd6);
      cnt_drv = 4'd9;
      @(negedge clk);
      check("t5_ready_level3", int'(push_ready_o), 1);
      @(posedge clk); #1;
      push_valid_i = 1'b0;
      cnt_drv = 4'd0;
      @(negedge clk);
      check("t5_level_stays3", int'(fifo_level_o), 3);
      @(posedge clk); #1;
      @(negedge clk);
      check("t5_head_advanced", int'(load_val_o), 3);
      cnt_drv = 4'd9;
      seen = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (fifo_level_o == 3'd0 && !busy_o) begin
            seen = 1'b1;
            break;
         end
      end
      enable_i = 1'b0;
      check("t5_drained", int'(seen), 1);
      wait_clean();

      // 6: enable dropped exactly at the terminal count
      do_reset();
      do_push(4'd8);
      term_val_i = 4'd5;
      cnt_drv = 4'd0;
      enable_i = 1'b1;
      @(posedge clk); #1;
      check("t6_armed", int'(busy_o), 1);
      enable_i = 1'b0;
      cnt_drv = 4'd5;
      @(negedge clk);
      check("t6_no_load", int'(load_o), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t6_idle", int'(busy_o), 0);
      check("t6_level_kept", int'(fifo_level_o), 1);
      check("t6_underrun", int'(underrun_o), 0);
      wait_clean();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
